fwd_scoreboard: RTL and testbench

Parametrised forwarding/hazard scoreboard for the RV32IMC pipeline. It replaces fixed per-stage rd comparisons with a per-register table of in-flight writers, each tagged with its pipeline age and result latency. The table drives the ID-stage operand forwarding selects and the interlock stall, so multi-cycle producers (loads, multiplies) stall exactly as long as needed. It sits beside the ID/EXE register and is updated on every issue.

---
 rtl/fwd_scoreboard_if.sv | 41 ++++
 rtl/fwd_scoreboard.sv | 113 +++++++++++
 tb/tb_fwd_scoreboard.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_if.sv
// Bundle of issue, operand-lookup and status signals between the ID stage
// and the forwarding/hazard scoreboard.
//
// Issue handshake: iss_valid is the request and !hz_stall is the ready. An
// instruction issues on a rising edge only when iss_valid=1, hz_stall=0,
// stall_ext=0 and flush_all=0. The ID stage holds its instruction (and
// iss_*) stable until that edge. hz_stall depends only on table state and
// id_rs/id_rs_used, never on iss_*.
interface fwd_scoreboard_if #(
    parameter int NSRC  = 2,
    parameter int DEPTH = 3,
    parameter int SEL_W = $clog2(DEPTH + 1),
    parameter int CNT_W = 16
);
    logic                  iss_valid;
    logic [4:0]            iss_rd;
    logic                  iss_wr_en;
    logic [SEL_W-1:0]      iss_lat;
    logic [NSRC*5-1:0]     id_rs;
    logic [NSRC-1:0]       id_rs_used;
    logic                  stall_ext;
    logic                  flush_all;
    logic [NSRC*SEL_W-1:0] fw_sel;
    logic                  hz_stall;
    logic                  busy;
    logic [CNT_W-1:0]      stall_cnt;

    // ID-stage side: drives the instruction, observes selects and stall
    modport master (
        output iss_valid, iss_rd, iss_wr_en, iss_lat,
        output id_rs, id_rs_used, stall_ext, flush_all,
        input  fw_sel, hz_stall, busy, stall_cnt
    );

    // Scoreboard side
    modport slave (
        input  iss_valid, iss_rd, iss_wr_en, iss_lat,
        input  id_rs, id_rs_used, stall_ext, flush_all,
        output fw_sel, hz_stall, busy, stall_cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Per-register table of in-flight writers (x1..x31). Each entry records how
// many stages past issue the writer is (age) and the first stage whose output
// carries its result (lat). ID operands forward from stage 'age' once
// age >= lat, otherwise they interlock.
module fwd_scoreboard #(
    parameter int NSRC  = 2,
    parameter int DEPTH = 3,
    parameter int SEL_W = $clog2(DEPTH + 1),
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             nrst,
    fwd_scoreboard_if.slave bus
);
    localparam logic [SEL_W-1:0] DEPTH_S = SEL_W'(DEPTH);
    localparam logic [SEL_W-1:0] ONE_S   = SEL_W'(1);

    // Entry 0 exists only to keep indexing simple; it is never allocated.
    logic [31:0]           v_q, v_d;
    logic [SEL_W-1:0]      age_q [32];
    logic [SEL_W-1:0]      age_d [32];
    logic [SEL_W-1:0]      lat_q [32];
    logic [SEL_W-1:0]      lat_d [32];
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [NSRC-1:0]       req;
    logic [NSRC*SEL_W-1:0] sel;
    logic                  hz;
    logic                  issue_fire;
    logic [SEL_W-1:0]      lat_clamped;

    // Operand lookup: forward when the producer's result exists, else stall
    always_comb begin
        sel = '0;
        req = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.id_rs_used[i] && (bus.id_rs[5*i +: 5] != 5'd0) &&
                v_q[bus.id_rs[5*i +: 5]]) begin
                if (age_q[bus.id_rs[5*i +: 5]] >= lat_q[bus.id_rs[5*i +: 5]])
                    sel[SEL_W*i +: SEL_W] = age_q[bus.id_rs[5*i +: 5]];
                else
                    req[i] = 1'b1;
            end
        end
    end

    assign hz         = |req;
    assign issue_fire = bus.iss_valid & ~hz & ~bus.stall_ext & ~bus.flush_all;

    // Latency clamp: 0 behaves as an EXE result, anything deeper as the last stage
    always_comb begin
        lat_clamped = bus.iss_lat;
        if (bus.iss_lat == '0)
            lat_clamped = ONE_S;
        else if (bus.iss_lat > DEPTH_S)
            lat_clamped = DEPTH_S;
    end

    // Table next state: flush beats freeze beats advance; a new issue beats age-out
    always_comb begin
        v_d   = v_q;
        age_d = age_q;
        lat_d = lat_q;
        if (bus.flush_all) begin
            v_d = '0;
        end else if (!bus.stall_ext) begin
            for (int r = 1; r < 32; r++) begin
                if (v_q[r]) begin
                    if (age_q[r] >= DEPTH_S)
                        v_d[r] = 1'b0;
                    else
                        age_d[r] = age_q[r] + ONE_S;
                end
            end
            if (issue_fire && bus.iss_wr_en && (bus.iss_rd != 5'd0)) begin
                v_d[bus.iss_rd]   = 1'b1;
                age_d[bus.iss_rd] = ONE_S;
                lat_d[bus.iss_rd] = lat_clamped;
            end
        end
    end

    // Hazard-stall counter, frozen cycles excluded, saturating at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (hz && !bus.stall_ext && !bus.flush_all && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // State registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            v_q   <= '0;
            cnt_q <= '0;
            for (int r = 0; r < 32; r++) begin
                age_q[r] <= '0;
                lat_q[r] <= '0;
            end
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
            for (int r = 0; r < 32; r++) begin
                age_q[r] <= age_d[r];
                lat_q[r] <= lat_d[r];
            end
        end
    end

    assign bus.fw_sel    = sel;
    assign bus.hz_stall  = hz;
    assign bus.busy      = |v_q;
    assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard at NSRC=2, DEPTH=3: a vector table for the
// single-writer pipelines plus hand sequences for freeze, overwrite race,
// flush and asynchronous reset.
module tb_fwd_scoreboard;
    localparam int EXP_W = 16 + 2 + 2 + 1 + 1;

    logic clk;
    logic nrst;

    fwd_scoreboard_if #(.NSRC(2), .DEPTH(3), .CNT_W(16)) bus ();

    fwd_scoreboard #(.NSRC(2), .DEPTH(3), .CNT_W(16)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    typedef struct {
        logic       iv;
        logic [4:0] rd;
        logic       we;
        logic [1:0] lat;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic       sx;
        logic       fl;
        logic [1:0] f0;
        logic [1:0] f1;
        logic       hz;
        logic       bz;
    } vec_t;

    logic [EXP_W-1:0] exp_q[$];
    logic [15:0]      exp_cnt;
    int               n_vec;
    int               n_bad;
    vec_t             tbl[23];

    // clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic iv, input logic [4:0] rd, input logic we,
                                input logic [1:0] lat, input logic [4:0] rs0,
                                input logic [4:0] rs1, input logic [1:0] used,
                                input logic sx, input logic fl, input logic [1:0] f0,
                                input logic [1:0] f1, input logic hz, input logic bz);
        vec_t v;
        v.iv = iv;  v.rd = rd;   v.we = we;     v.lat = lat;
        v.rs0 = rs0; v.rs1 = rs1; v.used = used; v.sx = sx; v.fl = fl;
        v.f0 = f0;  v.f1 = f1;   v.hz = hz;     v.bz = bz;
        return v;
    endfunction

    // scoreboard: pop the oldest expectation and compare with sampled outputs
    task automatic check(input string name);
        logic [EXP_W-1:0] got;
        logic [EXP_W-1:0] exp;
        got = {bus.stall_cnt, bus.fw_sel[3:2], bus.fw_sel[1:0], bus.hz_stall, bus.busy};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: no expectation queued, got %h", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                n_bad++;
                $display("FAIL %s: got cnt=%0d fw1=%0d fw0=%0d hz=%0b busy=%0b, expected cnt=%0d fw1=%0d fw0=%0d hz=%0b busy=%0b",
                         name, got[21:6], got[5:4], got[3:2], got[1], got[0],
                         exp[21:6], exp[5:4], exp[3:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic drive(input vec_t v);
        bus.iss_valid  = v.iv;
        bus.iss_rd     = v.rd;
        bus.iss_wr_en  = v.we;
        bus.iss_lat    = v.lat;
        bus.id_rs      = {v.rs1, v.rs0};
        bus.id_rs_used = v.used;
        bus.stall_ext  = v.sx;
        bus.flush_all  = v.fl;
    endtask

    // one cycle: drive after the falling edge, sample before the rising edge
    task automatic apply_vec(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        exp_q.push_back({exp_cnt, v.f1, v.f0, v.hz, v.bz});
        #2;
        check(name);
        if (v.hz && !v.sx && !v.fl && (exp_cnt != 16'hffff))
            exp_cnt = exp_cnt + 16'd1;
    endtask

    // outputs expected to read as all-zero right now (reset is asserted)
    task automatic expect_zero(input string name);
        exp_q.push_back('0);
        check(name);
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        exp_cnt = 16'd0;

        // iv rd we lat | rs0 rs1 used sx fl | f0 f1 hz busy
        tbl[0]  = mk(1,  5, 1, 1,   0,  0, 2'b00, 0, 0,  0, 0, 0, 0); // ADD x5
        tbl[1]  = mk(0,  0, 0, 0,   5,  0, 2'b01, 0, 0,  1, 0, 0, 1);
        tbl[2]  = mk(0,  0, 0, 0,   5,  0, 2'b01, 0, 0,  2, 0, 0, 1);
        tbl[3]  = mk(0,  0, 0, 0,   5,  0, 2'b01, 0, 0,  3, 0, 0, 1);
        tbl[4]  = mk(0,  0, 0, 0,   5,  0, 2'b01, 0, 0,  0, 0, 0, 0);
        tbl[5]  = mk(1,  6, 1, 2,   0,  0, 2'b00, 0, 0,  0, 0, 0, 0); // LW x6
        tbl[6]  = mk(1,  9, 1, 1,   6,  0, 2'b01, 0, 0,  0, 0, 1, 1); // load-use
        tbl[7]  = mk(1,  9, 1, 1,   6,  0, 2'b01, 0, 0,  2, 0, 0, 1);
        tbl[8]  = mk(0,  0, 0, 0,   9,  6, 2'b11, 0, 0,  1, 3, 0, 1);
        tbl[9]  = mk(0,  0, 0, 0,   9,  6, 2'b11, 0, 0,  2, 0, 0, 1);
        tbl[10] = mk(0,  0, 0, 0,   0,  0, 2'b00, 0, 0,  0, 0, 0, 1);
        tbl[11] = mk(0,  0, 0, 0,   0,  0, 2'b00, 0, 0,  0, 0, 0, 0);
        tbl[12] = mk(1,  0, 1, 1,   0,  0, 2'b01, 0, 0,  0, 0, 0, 0); // write x0
        tbl[13] = mk(1, 10, 0, 1,   0,  0, 2'b01, 0, 0,  0, 0, 0, 0); // no write
        tbl[14] = mk(1, 11, 1, 3,  10,  0, 2'b01, 0, 0,  0, 0, 0, 0); // MUL x11
        tbl[15] = mk(0,  0, 0, 0,  11, 11, 2'b00, 0, 0,  0, 0, 0, 1); // unused rs
        tbl[16] = mk(0,  0, 0, 0,   0, 11, 2'b10, 0, 0,  0, 0, 1, 1);
        tbl[17] = mk(0,  0, 0, 0,   0, 11, 2'b10, 0, 0,  0, 3, 0, 1);
        tbl[18] = mk(1, 12, 1, 0,   0,  0, 2'b00, 0, 0,  0, 0, 0, 0); // lat 0 -> 1
        tbl[19] = mk(0,  0, 0, 0,  12,  0, 2'b01, 0, 0,  1, 0, 0, 1);
        tbl[20] = mk(0,  0, 0, 0,   0,  0, 2'b00, 0, 0,  0, 0, 0, 1);
        tbl[21] = mk(0,  0, 0, 0,   0,  0, 2'b00, 0, 0,  0, 0, 0, 1);
        tbl[22] = mk(0,  0, 0, 0,   0,  0, 2'b00, 0, 0,  0, 0, 0, 0);

        // reset with a matching, used operand on ID: outputs must stay quiet
        nrst = 1'b0;
        drive(mk(1, 5, 1, 1, 5, 5, 2'b11, 0, 0, 0, 0, 0, 0));
        #2;
        expect_zero("reset_state");
        @(posedge clk);
        @(posedge clk);
        #1 nrst = 1'b1;

        for (int i = 0; i < 23; i++)
            apply_vec(tbl[i], $sformatf("tbl[%0d]", i));

        // multiply on both operands with a two-cycle freeze in the middle
        apply_vec(mk(1,  7, 1, 3,  0, 0, 2'b00, 0, 0, 0, 0, 0, 0), "mul_issue");
        apply_vec(mk(1, 13, 1, 1,  7, 7, 2'b11, 0, 0, 0, 0, 1, 1), "mul_stall1");
        apply_vec(mk(1, 13, 1, 1,  7, 7, 2'b11, 1, 0, 0, 0, 1, 1), "mul_frz1");
        apply_vec(mk(1, 13, 1, 1,  7, 7, 2'b11, 1, 0, 0, 0, 1, 1), "mul_frz2");
        apply_vec(mk(1, 13, 1, 1,  7, 7, 2'b11, 0, 0, 0, 0, 1, 1), "mul_stall2");
        apply_vec(mk(1, 13, 1, 1,  7, 7, 2'b11, 0, 0, 3, 3, 0, 1), "mul_fwd");
        for (int i = 0; i < 3; i++)
            apply_vec(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1), $sformatf("mul_drain%0d", i));
        apply_vec(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0), "mul_empty");

        // ADD x8, NOP, NOP, LW x8: LW allocates on the age-out edge
        apply_vec(mk(1, 8, 1, 1,  0, 0, 2'b00, 0, 0, 0, 0, 0, 0), "race_add");
        apply_vec(mk(0, 0, 0, 0,  0, 0, 2'b00, 0, 0, 0, 0, 0, 1), "race_nop1");
        apply_vec(mk(0, 0, 0, 0,  0, 0, 2'b00, 0, 0, 0, 0, 0, 1), "race_nop2");
        apply_vec(mk(1, 8, 1, 2,  8, 0, 2'b01, 0, 0, 3, 0, 0, 1), "race_lw");
        apply_vec(mk(1, 14, 0, 1, 8, 0, 2'b01, 0, 0, 0, 0, 1, 1), "race_stall");
        apply_vec(mk(1, 14, 0, 1, 8, 0, 2'b01, 0, 0, 2, 0, 0, 1), "race_fwd");
        apply_vec(mk(0, 0, 0, 0,  0, 0, 2'b00, 0, 0, 0, 0, 0, 1), "race_drain");
        apply_vec(mk(0, 0, 0, 0,  0, 0, 2'b00, 0, 0, 0, 0, 0, 0), "race_empty");

        // three writers in flight, then flush together with a freeze
        apply_vec(mk(1, 1, 1, 1,  0, 0, 2'b00, 0, 0, 0, 0, 0, 0), "fl_w1");
        apply_vec(mk(1, 2, 1, 2,  0, 0, 2'b00, 0, 0, 0, 0, 0, 1), "fl_w2");
        apply_vec(mk(1, 3, 1, 3,  0, 0, 2'b00, 0, 0, 0, 0, 0, 1), "fl_w3");
        apply_vec(mk(0, 0, 0, 0,  1, 3, 2'b11, 1, 1, 3, 0, 1, 1), "fl_flush");
        apply_vec(mk(0, 0, 0, 0,  1, 3, 2'b11, 0, 0, 0, 0, 0, 0), "fl_after");

        // asynchronous reset in the middle of a stall
        apply_vec(mk(1, 4, 1, 3,  0, 0, 2'b00, 0, 0, 0, 0, 0, 0), "rst_issue");
        apply_vec(mk(0, 0, 0, 0,  4, 0, 2'b01, 0, 0, 0, 0, 1, 1), "rst_stall");
        #1 nrst = 1'b0;
        #1;
        expect_zero("rst_async");
        exp_cnt = 16'd0;
        @(posedge clk);
        #1 nrst = 1'b1;
        apply_vec(mk(0, 0, 0, 0,  4, 0, 2'b01, 0, 0, 0, 0, 0, 0), "rst_after");

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
